vram_fifo_port: RTL



---
 rtl/vram_fifo_port_pkg.sv | 14 +
 rtl/vram_fifo_port_if.sv | 42 ++++
 rtl/vram_fifo_port_sync_fifo.sv | 57 +++++
 rtl/vram_fifo_port.sv | 131 +++++++++++++
 4 files changed

// File: rtl/vram_fifo_port_pkg.sv
// Shared types and default sizing for the VRAM FIFO port.
package vram_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   localparam int VRAM_ADDR_W = 25;
   localparam int VRAM_DATA_W = 16;
   localparam int VRAM_DEPTH  = 8;

endpackage

// File: rtl/vram_fifo_port_if.sv
// Client-side FIFO port plus Avalon-MM master bus of the VRAM FIFO port.
interface vram_fifo_port_if
   import vram_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W
);
   logic              write_ld;
   logic [ADDR_W-1:0] writeaddr;
   logic              write_req;
   logic [DATA_W-1:0] writedata;
   logic              wr_full;
   logic              read_ld;
   logic [ADDR_W-1:0] readaddr;
   logic              read_req;
   logic [DATA_W-1:0] readdata;
   logic              rd_empty;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic              mem_read;
   logic              mem_waitrequest;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_readdatavalid;

   modport master (
      output write_ld, writeaddr, write_req, writedata,
      output read_ld, readaddr, read_req,
      output mem_waitrequest, mem_readdata, mem_readdatavalid,
      input  wr_full, readdata, rd_empty,
      input  mem_address, mem_write, mem_writedata, mem_read
   );

   modport slave (
      input  write_ld, writeaddr, write_req, writedata,
      input  read_ld, readaddr, read_req,
      input  mem_waitrequest, mem_readdata, mem_readdatavalid,
      output wr_full, readdata, rd_empty,
      output mem_address, mem_write, mem_writedata, mem_read
   );

endinterface

// File: rtl/vram_fifo_port_sync_fifo.sv
// Synchronous show-ahead FIFO with flush; full/empty registered, dout is 0 when empty.
module sync_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic                       i_flush,
   input  logic [DATA_W-1:0]          i_din,
   output logic [DATA_W-1:0]          o_dout,
   output logic [$clog2(DEPTH):0]     o_count,
   output logic                       o_full,
   output logic                       o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]     r_wp, r_rp;
   logic [CW-1:0]     r_count;
   logic              r_full, r_empty;
   logic              w_push, w_pop;
   logic [CW-1:0]     w_count_nxt;

   // Push while full and pop while empty are dropped.
   assign w_push      = i_push && !r_full;
   assign w_pop       = i_pop && !r_empty;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) r_mem[r_wp] <= i_din;
   end

   always_ff @(posedge clk) begin
      if (reset || i_flush) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wp <= r_wp + AW'(1);
         if (w_pop)  r_rp <= r_rp + AW'(1);
         r_count <= w_count_nxt;
         r_full  <= (w_count_nxt == CW'(DEPTH));
         r_empty <= (w_count_nxt == '0);
      end
   end

   assign o_dout  = r_empty ? '0 : r_mem[r_rp];
   assign o_count = r_count;
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/vram_fifo_port.sv
// VRAM FIFO port: write FIFO drains to memory, read FIFO fed by prefetch.
// Optional VRAM_PORT_RAW_GUARD_EN holds off prefetch while writes are pending.
module vram_fifo_port
   import vram_pkg::*;
#(
   parameter int ADDR_W = VRAM_ADDR_W,
   parameter int DATA_W = VRAM_DATA_W,
   parameter int DEPTH  = VRAM_DEPTH
) (
   input logic             clk,
   input logic             reset,
   vram_fifo_port_if.slave bus
);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] FILL_LIM = (CW+1)'(DEPTH);

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_wa, r_ra, r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic [CW-1:0]     r_outstanding, r_discard;
   logic              r_wr_flushed;

   logic [DATA_W-1:0] w_wr_dout;
   logic [CW-1:0]     w_wr_count, w_rd_count;
   logic              w_wr_full, w_wr_empty, w_rd_full, w_rd_empty;
   logic              w_accept, w_wr_pop, w_rd_push, w_pf_ok;
   logic              w_issue_wr, w_issue_rd;
   logic [CW:0]       w_fill;
   logic              w_unused;

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_wr_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (bus.write_req),
      .i_pop   (w_wr_pop),
      .i_flush (bus.write_ld),
      .i_din   (bus.writedata),
      .o_dout  (w_wr_dout),
      .o_count (w_wr_count),
      .o_full  (w_wr_full),
      .o_empty (w_wr_empty)
   );

   sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rd_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_rd_push),
      .i_pop   (bus.read_req),
      .i_flush (bus.read_ld),
      .i_din   (bus.mem_readdata),
      .o_dout  (bus.readdata),
      .o_count (w_rd_count),
      .o_full  (w_rd_full),
      .o_empty (w_rd_empty)
   );

   assign w_unused = ^{w_wr_count, w_rd_full};
   assign w_fill   = {1'b0, w_rd_count} + {1'b0, r_outstanding};

`ifdef VRAM_PORT_RAW_GUARD_EN
   assign w_pf_ok = (w_fill < FILL_LIM) && w_wr_empty && (r_state != WR);
`else
   assign w_pf_ok = (w_fill < FILL_LIM);
`endif

   assign w_accept  = (r_state != IDLE) && !bus.mem_waitrequest;
   // A write issued before a flush completes but must not pop the refilled FIFO.
   assign w_wr_pop  = w_accept && (r_state == WR) && !r_wr_flushed && !bus.write_ld;
   assign w_rd_push = bus.mem_readdatavalid && (r_discard == '0) && !bus.read_ld;

   always_comb begin
      w_state_nxt = r_state;
      w_issue_wr  = 1'b0;
      w_issue_rd  = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_wr_empty && !bus.write_ld) begin
               w_state_nxt = WR;
               w_issue_wr  = 1'b1;
            end else if (w_pf_ok && !bus.read_ld) begin
               w_state_nxt = RD;
               w_issue_rd  = 1'b1;
            end
         end
         WR, RD:  if (!bus.mem_waitrequest) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state       <= IDLE;
         r_wa          <= '0;
         r_ra          <= '0;
         r_mem_addr    <= '0;
         r_mem_wdata   <= '0;
         r_outstanding <= '0;
         r_discard     <= '0;
         r_wr_flushed  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_issue_wr) begin
            r_mem_addr  <= r_wa;
            r_mem_wdata <= w_wr_dout;
         end else if (w_issue_rd) begin
            r_mem_addr  <= r_ra;
         end
         if (bus.write_ld)    r_wa <= bus.writeaddr;
         else if (w_issue_wr) r_wa <= r_wa + ADDR_W'(1);
         if (bus.read_ld)     r_ra <= bus.readaddr;
         else if (w_issue_rd) r_ra <= r_ra + ADDR_W'(1);
         if (r_state == IDLE)   r_wr_flushed <= 1'b0;
         else if (bus.write_ld) r_wr_flushed <= 1'b1;
         r_outstanding <= r_outstanding + CW'(w_accept && (r_state == RD))
                          - CW'(bus.mem_readdatavalid);
         // Stale reads: in flight, plus a pending RD command, minus one returning now.
         if (bus.read_ld)
            r_discard <= r_outstanding + CW'(r_state == RD) - CW'(bus.mem_readdatavalid);
         else if (bus.mem_readdatavalid && (r_discard != '0))
            r_discard <= r_discard - CW'(1);
      end
   end

   assign bus.mem_write     = (r_state == WR);
   assign bus.mem_read      = (r_state == RD);
   assign bus.mem_address   = r_mem_addr;
   assign bus.mem_writedata = r_mem_wdata;
   assign bus.wr_full       = w_wr_full;
   assign bus.rd_empty      = w_rd_empty;

endmodule
